// File: rtl/bsg_ral_link_test_ctrl.sv
// Run controller for one master bsg_ral_link_to_sdr_test_node: injects N flits,
// waits for loopback drain, and judges the run from counter deltas and error_i.
module bsg_ral_link_test_ctrl #(
  parameter int unsigned timeout_p        = 1024,
  parameter int unsigned timeout_width_lp = $clog2(timeout_p + 1)
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [31:0] num_packets_i,
  output logic        en_o,
  input  logic        error_i,
  input  logic [31:0] sent_i,
  input  logic [31:0] received_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [1:0]  fail_code_o,
  output logic [31:0] sent_delta_o,
  output logic [31:0] received_delta_o
);

  localparam int unsigned cnt_width_lp  = 32;
  localparam int unsigned code_width_lp = 2;

  localparam logic [code_width_lp-1:0] code_none_lp  = 2'd0;
  localparam logic [code_width_lp-1:0] code_error_lp = 2'd1;
  localparam logic [code_width_lp-1:0] code_stall_lp = 2'd2;
  localparam logic [code_width_lp-1:0] code_drain_lp = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [cnt_width_lp-1:0]    n_q, n_d;
  logic [cnt_width_lp-1:0]    sent_base_q, sent_base_d;
  logic [cnt_width_lp-1:0]    recv_base_q, recv_base_d;
  logic [cnt_width_lp-1:0]    prev_q, prev_d;
  logic [timeout_width_lp-1:0] idle_q, idle_d;
  logic                       done_q, done_d;
  logic                       pass_q, pass_d;
  logic [code_width_lp-1:0]   code_q, code_d;
  logic [code_width_lp-1:0]   end_code;

  logic [cnt_width_lp-1:0]     sent_delta, recv_delta, watch;
  logic [timeout_width_lp-1:0] idle_inc;
  logic                        timeout_hit;

  // Deltas against the run-start snapshot; wrap naturally in 32 bits
  assign sent_delta  = sent_i - sent_base_q;
  assign recv_delta  = received_i - recv_base_q;
  assign watch       = (state_q == DRAIN) ? received_i : sent_i;
  assign idle_inc    = (watch != prev_q) ? '0 : idle_q + timeout_width_lp'(1);
  assign timeout_hit = (idle_inc == timeout_width_lp'(timeout_p));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state, plus the fail code recorded on entry to DONE
  always_comb begin
    state_d  = state_q;
    end_code = code_none_lp;
    unique case (state_q)
      IDLE, DONE: if (start_i) state_d = ARM;
      ARM: begin
        if (error_i) begin
          state_d  = DONE;
          end_code = code_error_lp;
        end else if (n_q == '0) state_d = DONE;
        else                    state_d = RUN;
      end
      RUN: begin
        if (error_i) begin
          state_d  = DONE;
          end_code = code_error_lp;
        end else if (sent_delta >= n_q) state_d = DRAIN;
        else if (timeout_hit) begin
          state_d  = DONE;
          end_code = code_stall_lp;
        end
      end
      DRAIN: begin
        if (error_i) begin
          state_d  = DONE;
          end_code = code_error_lp;
        end else if (recv_delta == sent_delta) state_d = DONE;
        else if (timeout_hit) begin
          state_d  = DONE;
          end_code = code_drain_lp;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en_o        = (state_q == RUN) && (sent_delta < n_q);
    busy_o      = (state_q == ARM) || (state_q == RUN) || (state_q == DRAIN);
    n_d         = n_q;
    sent_base_d = sent_base_q;
    recv_base_d = recv_base_q;
    prev_d      = prev_q;
    idle_d      = idle_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    code_d      = code_q;

    if (((state_q == IDLE) || (state_q == DONE)) && start_i) begin
      n_d    = num_packets_i;
      pass_d = 1'b0;
      code_d = code_none_lp;
    end

    if (state_q == ARM) begin
      sent_base_d = sent_i;
      recv_base_d = received_i;
      prev_d      = sent_i;
      idle_d      = '0;
    end

    // Idle counter follows sent_i in RUN and received_i in DRAIN
    if ((state_q == RUN) || (state_q == DRAIN)) begin
      if (state_d == state_q) begin
        idle_d = idle_inc;
        prev_d = watch;
      end else if (state_d == DRAIN) begin
        idle_d = '0;
        prev_d = received_i;
      end
    end

    if ((state_d == DONE) && (state_q != DONE)) begin
      done_d = 1'b1;
      pass_d = (end_code == code_none_lp);
      code_d = end_code;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      n_q         <= '0;
      sent_base_q <= '0;
      recv_base_q <= '0;
      prev_q      <= '0;
      idle_q      <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      code_q      <= '0;
    end else begin
      n_q         <= n_d;
      sent_base_q <= sent_base_d;
      recv_base_q <= recv_base_d;
      prev_q      <= prev_d;
      idle_q      <= idle_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      code_q      <= code_d;
    end
  end

  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign fail_code_o      = code_q;
  assign sent_delta_o     = sent_delta;
  assign received_delta_o = recv_delta;

endmodule

// File: tb/tb_bsg_ral_link_test_ctrl.sv
// Bench for bsg_ral_link_test_ctrl: a simple loopback node plus a run-level model
// checked every cycle, and literal expectations for each directed scenario.
module tb_bsg_ral_link_test_ctrl;

  localparam int unsigned T = 16;
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;

  logic        clk = 1'b0;
  logic        reset_n, start, en, error, busy, done, pass;
  logic [31:0] num, sent, recv, sd, rd;
  logic [1:0]  code;

  always #5 clk = ~clk;

  bsg_ral_link_test_ctrl #(.timeout_p(T)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .num_packets_i(num),
    .en_o(en), .error_i(error), .sent_i(sent), .received_i(recv),
    .busy_o(busy), .done_o(done), .pass_o(pass), .fail_code_o(code),
    .sent_delta_o(sd), .received_delta_o(rd)
  );

  int checks = 0, failures = 0, cyc = 0;
  bit ready, ret_ok, done_seen;
  logic [31:0] recv_cap, recv_start;
  int hs_cnt, en_cnt, done_cyc;

  int          m_ph, m_idle;
  logic [31:0] m_n, m_sb, m_rb, m_prev;
  bit          m_done, m_pass;
  logic [1:0]  m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%08h expected=0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ph = P_IDLE; m_idle = 0; m_n = '0; m_sb = '0; m_rb = '0; m_prev = '0;
    m_done = 0; m_pass = 0; m_code = '0;
  endtask

  task automatic m_finish(input int c);
    m_ph = P_DONE; m_done = 1; m_code = 2'(c); m_pass = (c == 0);
  endtask

  // One run-level step from the inputs visible during this cycle
  task automatic model_step();
    logic [31:0] sdm, rdm;
    sdm = sent - m_sb;
    rdm = recv - m_rb;
    m_done = 0;
    if (m_ph == P_IDLE || m_ph == P_DONE) begin
      if (start) begin m_ph = P_ARM; m_n = num; m_pass = 0; m_code = '0; end
    end else if (m_ph == P_ARM) begin
      m_sb = sent; m_rb = recv; m_idle = 0; m_prev = sent;
      if (error) m_finish(1);
      else if (m_n == 0) m_finish(0);
      else m_ph = P_RUN;
    end else if (m_ph == P_RUN) begin
      if (error) m_finish(1);
      else if (sdm >= m_n) begin m_ph = P_DRAIN; m_idle = 0; m_prev = recv; end
      else begin
        m_idle = (sent == m_prev) ? m_idle + 1 : 0;
        m_prev = sent;
        if (m_idle == T) m_finish(2);
      end
    end else begin
      if (error) m_finish(1);
      else if (rdm == sdm) m_finish(0);
      else begin
        m_idle = (recv == m_prev) ? m_idle + 1 : 0;
        m_prev = recv;
        if (m_idle == T) m_finish(3);
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] esd, erd;
    esd = sent - m_sb;
    erd = recv - m_rb;
    chk("en_o", en, (m_ph == P_RUN) && (esd < m_n));
    chk("busy_o", busy, (m_ph == P_ARM) || (m_ph == P_RUN) || (m_ph == P_DRAIN));
    chk("done_o", done, m_done);
    chk("pass_o", pass, m_pass);
    chk("fail_code_o", code, m_code);
    chk("sent_delta_o", sd, esd);
    chk("received_delta_o", rd, erd);
  endtask

  // Check at negedge, then advance the node counters just after the edge
  task automatic tick();
    bit hs;
    @(negedge clk);
    check_outputs();
    if (done) begin done_seen = 1; done_cyc = cyc; end
    if (en) en_cnt++;
    hs = en && ready;
    model_step();
    @(posedge clk);
    #1;
    if (ret_ok && recv != sent && (recv - recv_start) < recv_cap) recv = recv + 1;
    if (hs) begin sent = sent + 1; hs_cnt++; end
    cyc++;
  endtask

  task automatic start_run(input logic [31:0] n, output int t0);
    hs_cnt = 0; en_cnt = 0; done_seen = 0; recv_start = recv;
    num = n; start = 1; t0 = cyc;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && !done_seen; i++) tick();
    if (!done_seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout cycle=%0d actual=no_done expected=done", name, cyc);
    end
    tick();
    tick();
  endtask

  int t0, te;

  initial begin
    reset_n = 0; start = 0; num = '0; error = 0; sent = '0; recv = '0;
    ready = 1; ret_ok = 1; recv_cap = 32'hFFFF_FFFF; recv_start = '0;
    m_reset();
    #12;
    chk("rst_en", en, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_pass", pass, 0); chk("rst_code", code, 0);
    chk("rst_sd", sd, 0); chk("rst_rd", rd, 0);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    tick(); tick();

    // Loopback N=5
    start_run(32'd5, t0);
    wait_done("n5");
    chk("n5_latency", 32'(done_cyc - t0), 32'd9);
    chk("n5_handshakes", 32'(hs_cnt), 32'd5);
    chk("n5_en_cycles", 32'(en_cnt), 32'd5);
    chk("n5_pass", pass, 1); chk("n5_code", code, 0);
    chk("n5_sd", sd, 32'd5); chk("n5_rd", rd, 32'd5);

    // N=0
    start_run(32'd0, t0);
    wait_done("n0");
    chk("n0_latency", 32'(done_cyc - t0), 32'd2);
    chk("n0_en_cycles", 32'(en_cnt), 32'd0);
    chk("n0_pass", pass, 1);

    // Counter wrap with bases at 0xFFFF_FFFE
    sent = 32'hFFFF_FFFE; recv = 32'hFFFF_FFFE;
    tick();
    start_run(32'd4, t0);
    wait_done("wrap");
    chk("wrap_pass", pass, 1); chk("wrap_code", code, 0);
    chk("wrap_sd", sd, 32'd4); chk("wrap_rd", rd, 32'd4);
    chk("wrap_sent_raw", sent, 32'd2);

    // Node error during a 10-flit run
    start_run(32'd10, t0);
    repeat (4) tick();
    error = 1; te = cyc;
    wait_done("err");
    chk("err_latency", 32'(done_cyc - te), 32'd1);
    chk("err_code", code, 32'd1); chk("err_pass", pass, 0);
    chk("err_en_after", en, 0);
    error = 0;
    tick();

    // Stall: node never ready
    ready = 0;
    start_run(32'd5, t0);
    wait_done("stall");
    chk("stall_latency", 32'(done_cyc - t0), 32'd18);
    chk("stall_code", code, 32'd2); chk("stall_pass", pass, 0);
    chk("stall_handshakes", 32'(hs_cnt), 32'd0);
    ready = 1;

    // Return path blocked after 3 of 8
    recv = sent; tick();
    recv_cap = 32'd3;
    start_run(32'd8, t0);
    wait_done("drain");
    chk("drain_code", code, 32'd3); chk("drain_pass", pass, 0);
    chk("drain_sd", sd, 32'd8); chk("drain_rd", rd, 32'd3);
    recv_cap = 32'hFFFF_FFFF;
    repeat (8) tick();

    // start_i while busy is ignored
    start_run(32'd6, t0);
    repeat (3) tick();
    num = 32'd99; start = 1; tick(); start = 0;
    wait_done("busy_start");
    chk("busy_start_handshakes", 32'(hs_cnt), 32'd6);
    chk("busy_start_pass", pass, 1); chk("busy_start_sd", sd, 32'd6);

    // Asynchronous reset mid-RUN
    start_run(32'd10, t0);
    repeat (4) tick();
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    chk("arst_en", en, 0); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    chk("arst_pass", pass, 0); chk("arst_code", code, 0);
    chk("arst_sd", sd, sent); chk("arst_rd", rd, recv);
    m_reset();
    @(posedge clk); #1;
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

endmodule
